// File: rtl/seg_pkg.sv
`timescale 1ns/1ps
// Shared constants and types for the seven-segment scan controller:
// digit count, cathode bit positions and the hex glyph table.
package seg_pkg;

  // Number of display digits and the width of a digit index
  localparam int NUM_DIGITS = 8;
  localparam int DIG_W      = 3;

  // Cathode bit positions within {dp,g,f,e,d,c,b,a}
  localparam int SEG_A  = 0;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high segment pattern {g,f,e,d,c,b,a}
  typedef logic [6:0] seg_t;

  // Glyphs for 0..F; entry 15 is listed first because this is a packed array
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Phase within a digit slot
  typedef enum logic {
    PH_BLANK,
    PH_SHOW
  } phase_e;

  // One buffered digit: hex nibble plus decimal point
  typedef struct packed {
    logic       dp;
    logic [3:0] data;
  } digit_t;

  // Active-low one-cold anode pattern for a given digit index
  function automatic logic [NUM_DIGITS-1:0] anodeSelect(input logic [DIG_W-1:0] dig);
    return ~(NUM_DIGITS'(1) << dig);
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
`timescale 1ns/1ps
// Combinational hex nibble to active-high seven-segment decoder.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output seg_t       seg_o
);

  // Straight table lookup; the caller inverts for active-low pins
  always_comb begin
    seg_o = SEG_TABLE[hex_i];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
`timescale 1ns/1ps
// Time-multiplexed scan controller for an 8-digit common-anode display.
// Clients fill a shadow buffer through a valid/ready port and commit it;
// the shadow is copied into the active buffer only at the end of a frame,
// so a frame is never drawn from a half-updated buffer.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned PRESCALE     = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DIG_W-1:0]      wr_addr,
  input  logic [3:0]            wr_data,
  input  logic                  wr_dp,
  input  logic                  commit,
  input  logic [NUM_DIGITS-1:0] digit_en,
  output logic                  frame_start,
  output logic [NUM_DIGITS-1:0] Anode,
  output logic [7:0]            Cathode
);

  localparam int unsigned CNT_W = $clog2(PRESCALE);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIG_W-1:0]      dig_q, dig_d;
  logic                  pending_q, pending_d;
  digit_t                shadow_q [NUM_DIGITS];
  digit_t                shadow_d [NUM_DIGITS];
  digit_t                active_q [NUM_DIGITS];
  digit_t                active_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [7:0]            cathode_q, cathode_d;
  logic                  frameStart_q, frameStart_d;

  logic   transferCycle;
  logic   wrFire;
  phase_e phase;
  digit_t curDigit;
  seg_t   curSeg;

  // Last cycle of the last digit's slot: the only point where active changes
  assign transferCycle = (dig_q == DIG_LAST) && (cnt_q == CNT_LAST);
  assign wrFire        = wr_valid & ~pending_q;
  assign wr_ready      = ~pending_q;
  assign curDigit      = active_q[dig_q];

  hex_to_seg u_hex_to_seg (
    .hex_i (curDigit.data),
    .seg_o (curSeg)
  );

  // Slot counter and digit index: dig advances each time cnt wraps
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    dig_d = dig_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
    end
  end

  // Pending flag: set by a commit, cleared by the frame-end transfer;
  // repeated commits while already pending are simply absorbed
  always_comb begin
    pending_d = pending_q;
    if (transferCycle && pending_q) begin
      pending_d = 1'b0;
    end else if (commit && !pending_q) begin
      pending_d = 1'b1;
    end
  end

  // Buffer update: writes land in shadow, transfer copies shadow to active
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wrFire) begin
      shadow_d[wr_addr] = '{dp: wr_dp, data: wr_data};
    end
    if (transferCycle && pending_q) begin
      active_d = shadow_q;
    end
  end

  // Pin values for the current (dig, cnt); registered below, so the pins
  // trail the counters by one cycle and digit_en acts within a slot
  always_comb begin
    phase        = (cnt_q < CNT_BLANK) ? PH_BLANK : PH_SHOW;
    anode_d      = '1;
    cathode_d    = '1;
    frameStart_d = (dig_q == '0) && (cnt_q == '0);
    if (phase == PH_SHOW && digit_en[dig_q]) begin
      anode_d                 = anodeSelect(dig_q);
      cathode_d[SEG_DP]       = ~curDigit.dp;
      cathode_d[SEG_G:SEG_A]  = ~curSeg;
    end
  end

  // Counters and pending flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      dig_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      pending_q <= pending_d;
    end
  end

  // Shadow and active digit buffers, cleared on reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  // Output registers driving the pins directly; dark while in reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      anode_q      <= '1;
      cathode_q    <= '1;
      frameStart_q <= 1'b0;
    end else begin
      anode_q      <= anode_d;
      cathode_q    <= cathode_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign Anode       = anode_q;
  assign Cathode     = cathode_q;
  assign frame_start = frameStart_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
`timescale 1ns/1ps
// Bench for seg_scan_ctrl with a small slot length. A frame-position model
// (position = cycles since reset modulo one frame) predicts the pins.
module tb_seg_scan_ctrl;

  localparam int PRESCALE = 8;
  localparam int BLANK    = 2;
  localparam int FRAME    = 8 * PRESCALE;

  logic       clock;
  logic       reset;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dp;
  logic       commit;
  logic [7:0] digit_en;
  logic       frame_start;
  logic [7:0] Anode;
  logic [7:0] Cathode;

  int testsRun;
  int testsFailed;

  int         mPos;
  bit         mPending;
  logic [3:0] mShData [8];
  logic       mShDp   [8];
  logic [3:0] mAcData [8];
  logic       mAcDp   [8];
  logic [6:0] segTab  [16];

  logic [7:0] expAnode;
  logic [7:0] expCathode;
  logic       expFrame;

  seg_scan_ctrl #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_dp       (wr_dp),
    .commit      (commit),
    .digit_en    (digit_en),
    .frame_start (frame_start),
    .Anode       (Anode),
    .Cathode     (Cathode)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Guard against a hung run
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  task automatic modelReset();
    mPos     = 0;
    mPending = 0;
    for (int i = 0; i < 8; i++) begin
      mShData[i] = 4'h0; mShDp[i] = 1'b0;
      mAcData[i] = 4'h0; mAcDp[i] = 1'b0;
    end
  endtask

  // Predict the pins produced from the current frame position, advance one
  // clock, then apply the write/commit/transfer rules to the model
  task automatic tick();
    int d, c;
    bit fire, xfer;
    d = mPos / PRESCALE;
    c = mPos % PRESCALE;
    if (c < BLANK || !digit_en[d]) begin
      expAnode   = 8'hFF;
      expCathode = 8'hFF;
    end else begin
      expAnode   = 8'hFF ^ (8'(1) << d);
      expCathode = ~{mAcDp[d], segTab[mAcData[d]]};
    end
    expFrame = (mPos == 0);
    fire = wr_valid && !mPending;
    xfer = (mPos == FRAME - 1);
    @(posedge clock);
    #1;
    if (xfer && mPending) begin
      for (int i = 0; i < 8; i++) begin
        mAcData[i] = mShData[i];
        mAcDp[i]   = mShDp[i];
      end
      mPending = 0;
    end else if (commit && !mPending) begin
      mPending = 1;
    end
    if (fire) begin
      mShData[wr_addr] = wr_data;
      mShDp[wr_addr]   = wr_dp;
    end
    mPos = (mPos + 1) % FRAME;
  endtask

  task automatic runTo(input int pos);
    for (int k = 0; k < FRAME && mPos != pos; k++) tick();
  endtask

  task automatic test_reset();
    if (Anode !== 8'hFF) begin testsFailed++; $display("[TB] FAIL reset_anode got=%h exp=ff", Anode); end
    testsRun++;
    if (Cathode !== 8'hFF) begin testsFailed++; $display("[TB] FAIL reset_cathode got=%h exp=ff", Cathode); end
    testsRun++;
    if (wr_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    testsRun++;
    if (frame_start !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_frame_start got=%b exp=0", frame_start); end
    testsRun++;
    tick(); tick(); tick();
    if (Anode !== 8'hFE) begin testsFailed++; $display("[TB] FAIL first_lit_anode got=%h exp=fe", Anode); end
    testsRun++;
    if (Cathode !== 8'hC0) begin testsFailed++; $display("[TB] FAIL first_lit_cathode got=%h exp=c0", Cathode); end
    testsRun++;
  endtask

  task automatic test_scan_order();
    int frames, lit;
    frames = 0;
    lit    = 0;
    digit_en = 8'hFF;
    runTo(0);
    for (int k = 0; k < FRAME; k++) begin
      tick();
      if (frame_start) frames++;
      if (Anode !== 8'hFF) lit++;
      if (Anode !== expAnode) begin testsFailed++; $display("[TB] FAIL scan_anode pos=%0d got=%h exp=%h", mPos, Anode, expAnode); end
      testsRun++;
      if (Cathode !== expCathode) begin testsFailed++; $display("[TB] FAIL scan_cathode pos=%0d got=%h exp=%h", mPos, Cathode, expCathode); end
      testsRun++;
      if (frame_start !== expFrame) begin testsFailed++; $display("[TB] FAIL scan_frame_start pos=%0d got=%b exp=%b", mPos, frame_start, expFrame); end
      testsRun++;
    end
    if (frames != 1) begin testsFailed++; $display("[TB] FAIL scan_frame_count got=%0d exp=1", frames); end
    testsRun++;
    if (lit != 8 * (PRESCALE - BLANK)) begin testsFailed++; $display("[TB] FAIL scan_lit_cycles got=%0d exp=%0d", lit, 8 * (PRESCALE - BLANK)); end
    testsRun++;
  endtask

  task automatic test_write_commit();
    int seen;
    runTo(10);
    if (wr_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL wc_ready_idle got=%b exp=1", wr_ready); end
    testsRun++;
    wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 4'hA; wr_dp = 1'b1;
    tick();
    wr_valid = 1'b0;
    commit   = 1'b1;
    tick();
    commit   = 1'b0;
    for (int k = 0; k < FRAME && mPos != 0; k++) begin
      if (wr_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL wc_ready_pending pos=%0d got=%b exp=0", mPos, wr_ready); end
      testsRun++;
      tick();
      if (Anode === 8'hF7 && Cathode !== 8'hC0) begin testsFailed++; $display("[TB] FAIL wc_old_frame pos=%0d got=%h exp=c0", mPos, Cathode); end
      testsRun++;
    end
    if (wr_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL wc_ready_after got=%b exp=1", wr_ready); end
    testsRun++;
    seen = 0;
    for (int k = 0; k < FRAME; k++) begin
      tick();
      if (Anode === 8'hF7) begin
        seen++;
        if (Cathode !== 8'h08) begin testsFailed++; $display("[TB] FAIL wc_new_frame pos=%0d got=%h exp=08", mPos, Cathode); end
        testsRun++;
      end
      if (Cathode !== expCathode) begin testsFailed++; $display("[TB] FAIL wc_cathode pos=%0d got=%h exp=%h", mPos, Cathode, expCathode); end
      testsRun++;
    end
    if (seen != PRESCALE - BLANK) begin testsFailed++; $display("[TB] FAIL wc_digit3_cycles got=%0d exp=%0d", seen, PRESCALE - BLANK); end
    testsRun++;
  endtask

  task automatic test_simultaneous();
    runTo(20);
    wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 4'h1; wr_dp = 1'b0;
    commit   = 1'b1;
    tick();
    wr_valid = 1'b0; commit = 1'b0;
    tick();
    commit   = 1'b1;
    wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 4'h7;
    tick();
    commit   = 1'b0; wr_valid = 1'b0;
    runTo(0);
    if (wr_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL sim_second_commit got=%b exp=1", wr_ready); end
    testsRun++;
    runTo(3);
    if (Anode !== 8'hFE) begin testsFailed++; $display("[TB] FAIL sim_anode got=%h exp=fe", Anode); end
    testsRun++;
    if (Cathode !== 8'hF9) begin testsFailed++; $display("[TB] FAIL sim_cathode got=%h exp=f9", Cathode); end
    testsRun++;
    tick();
    if (wr_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL sim_ready_stays got=%b exp=1", wr_ready); end
    testsRun++;
  endtask

  task automatic test_transfer_commit();
    runTo(FRAME - 1);
    if (wr_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL xc_ready_before got=%b exp=1", wr_ready); end
    testsRun++;
    wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 4'h5; wr_dp = 1'b0;
    commit   = 1'b1;
    tick();
    wr_valid = 1'b0; commit = 1'b0;
    if (wr_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL xc_pending got=%b exp=0", wr_ready); end
    testsRun++;
    runTo(19);
    if (Anode !== 8'hFB) begin testsFailed++; $display("[TB] FAIL xc_anode_old got=%h exp=fb", Anode); end
    testsRun++;
    if (Cathode !== 8'hC0) begin testsFailed++; $display("[TB] FAIL xc_no_swap got=%h exp=c0", Cathode); end
    testsRun++;
    runTo(0);
    runTo(19);
    if (Anode !== 8'hFB) begin testsFailed++; $display("[TB] FAIL xc_anode_new got=%h exp=fb", Anode); end
    testsRun++;
    if (Cathode !== 8'h92) begin testsFailed++; $display("[TB] FAIL xc_swap got=%h exp=92", Cathode); end
    testsRun++;
  endtask

  task automatic test_masking();
    digit_en = 8'hFF;
    runTo(4);
    if (Anode !== 8'hFE) begin testsFailed++; $display("[TB] FAIL mask_before got=%h exp=fe", Anode); end
    testsRun++;
    digit_en = 8'hFE;
    tick();
    if (Anode !== 8'hFF) begin testsFailed++; $display("[TB] FAIL mask_anode got=%h exp=ff", Anode); end
    testsRun++;
    if (Cathode !== 8'hFF) begin testsFailed++; $display("[TB] FAIL mask_cathode got=%h exp=ff", Cathode); end
    testsRun++;
    runTo(11);
    if (Anode !== 8'hFD) begin testsFailed++; $display("[TB] FAIL mask_other_anode got=%h exp=fd", Anode); end
    testsRun++;
    if (Cathode !== expCathode) begin testsFailed++; $display("[TB] FAIL mask_other_cathode got=%h exp=%h", Cathode, expCathode); end
    testsRun++;
    digit_en = 8'hFF;
  endtask

  task automatic test_random();
    for (int k = 0; k < 6 * FRAME; k++) begin
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_addr  = 3'($urandom_range(0, 7));
      wr_data  = 4'($urandom_range(0, 15));
      wr_dp    = 1'($urandom_range(0, 1));
      commit   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) digit_en = 8'($urandom);
      tick();
      if (Anode !== expAnode) begin testsFailed++; $display("[TB] FAIL rand_anode pos=%0d got=%h exp=%h", mPos, Anode, expAnode); end
      testsRun++;
      if (Cathode !== expCathode) begin testsFailed++; $display("[TB] FAIL rand_cathode pos=%0d got=%h exp=%h", mPos, Cathode, expCathode); end
      testsRun++;
      if (frame_start !== expFrame) begin testsFailed++; $display("[TB] FAIL rand_frame_start pos=%0d got=%b exp=%b", mPos, frame_start, expFrame); end
      testsRun++;
      if (wr_ready !== !mPending) begin testsFailed++; $display("[TB] FAIL rand_wr_ready pos=%0d got=%b exp=%b", mPos, wr_ready, !mPending); end
      testsRun++;
    end
    wr_valid = 1'b0; commit = 1'b0; digit_en = 8'hFF;
  endtask

  task automatic test_reset_mid();
    runTo(5);
    if (Anode !== 8'hFE) begin testsFailed++; $display("[TB] FAIL rmid_lit got=%h exp=fe", Anode); end
    testsRun++;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    if (wr_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL rmid_pending got=%b exp=0", wr_ready); end
    testsRun++;
    #2 reset = 1'b1;
    #1;
    if (Anode !== 8'hFF) begin testsFailed++; $display("[TB] FAIL rmid_anode got=%h exp=ff", Anode); end
    testsRun++;
    if (Cathode !== 8'hFF) begin testsFailed++; $display("[TB] FAIL rmid_cathode got=%h exp=ff", Cathode); end
    testsRun++;
    if (wr_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL rmid_wr_ready got=%b exp=1", wr_ready); end
    testsRun++;
    modelReset();
    #3 reset = 1'b0;
    tick(); tick(); tick();
    if (Anode !== 8'hFE) begin testsFailed++; $display("[TB] FAIL rmid_first_anode got=%h exp=fe", Anode); end
    testsRun++;
    if (Cathode !== 8'hC0) begin testsFailed++; $display("[TB] FAIL rmid_cleared got=%h exp=c0", Cathode); end
    testsRun++;
  endtask

  // Scenario sequence
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    segTab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_addr  = 3'd0;
    wr_data  = 4'h0;
    wr_dp    = 1'b0;
    commit   = 1'b0;
    digit_en = 8'hFF;
    modelReset();
    #23 reset = 1'b0;
    test_reset();
    test_scan_order();
    test_write_commit();
    test_simultaneous();
    test_transfer_commit();
    test_masking();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
